// File: rtl/count_capture_pkg.sv
// Shared types and constants for the counter-capture FIFO.
// Entry layout is {tc, value}; a timestamp is prepended when stored.
package count_capture_pkg;

  localparam int CW_DEF = 4;
  localparam logic [CW_DEF-1:0] TC_VAL = {CW_DEF{1'b1}};
  localparam int DROP_W = 8;

  typedef struct packed {
    logic              tc;
    logic [CW_DEF-1:0] value;
  } entry_t;

  localparam int ENTRY_W = $bits(entry_t);

endpackage

// File: rtl/count_capture_mem.sv
// DEPTH x W register array, one write port, registered head read.
// A same-cycle write to the head address is bypassed into the read register.
module count_capture_mem #(
  parameter int DEPTH = 8,
  parameter int W     = 5
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     wr_en,
  input  logic [$clog2(DEPTH)-1:0] wr_ptr,
  input  logic [W-1:0]             wr_data,
  input  logic [$clog2(DEPTH)-1:0] rd_ptr,
  output logic [W-1:0]             rd_data
);

  logic [W-1:0] mem_q [DEPTH];
  logic [W-1:0] rd_data_d, rd_data_q;

  always_comb begin
    rd_data_d = mem_q[rd_ptr];
    if (wr_en && (wr_ptr == rd_ptr))
      rd_data_d = wr_data;
  end

  always_ff @(posedge clk) begin
    if (wr_en)
      mem_q[wr_ptr] <= wr_data;
  end

  always_ff @(posedge clk) begin
    if (reset)
      rd_data_q <= '0;
    else
      rd_data_q <= rd_data_d;
  end

  assign rd_data = rd_data_q;

endmodule

// File: rtl/count_capture_fifo.sv
// Captures counter value changes into a FIFO with overrun tracking.
// Optional COUNT_CAPTURE_TSTAMP_EN stores a cycle timestamp per entry.
module count_capture_fifo
  import count_capture_pkg::*;
#(
  parameter int DEPTH = 8,
  parameter int CW    = CW_DEF,
  parameter int TSW   = 8
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic [CW-1:0]              count_in,
  input  logic                       sample_en,
  output logic                       out_valid,
  input  logic                       out_ready,
  output logic [CW:0]                out_data,
  output logic [TSW-1:0]             out_tstamp,
  output logic [$clog2(DEPTH):0]     level,
  output logic                       overflow,
  output logic [DROP_W-1:0]          drop_cnt,
  input  logic                       ovf_clr
);

  localparam int PW = $clog2(DEPTH);
  localparam int LW = PW + 1;
`ifdef COUNT_CAPTURE_TSTAMP_EN
  localparam int EW = ENTRY_W + TSW;
`else
  localparam int EW = ENTRY_W;
`endif

  logic [CW-1:0]     last_val_q, last_val_d;
  logic              last_vld_q, last_vld_d;
  logic [PW-1:0]     wr_ptr_q, wr_ptr_d;
  logic [PW-1:0]     rd_ptr_q, rd_ptr_d;
  logic [LW-1:0]     level_q, level_d;
  logic              overflow_q, overflow_d;
  logic [DROP_W-1:0] drop_cnt_q, drop_cnt_d;

  logic   push_req, pop, full, wr_en, drop;
  entry_t ent;
  logic [EW-1:0] wr_data, rd_data;

  always_comb begin
    ent.tc    = (count_in == TC_VAL);
    ent.value = count_in;
    push_req  = sample_en &&
                (!last_vld_q || (count_in != last_val_q));
    pop       = (level_q != '0) && out_ready;
    full      = (level_q == LW'(DEPTH));
    wr_en     = push_req && (!full || pop);
    drop      = push_req && full && !pop;

    last_val_d = push_req ? count_in : last_val_q;
    last_vld_d = last_vld_q || push_req;
    wr_ptr_d   = wr_en ? wr_ptr_q + PW'(1) : wr_ptr_q;
    rd_ptr_d   = pop ? rd_ptr_q + PW'(1) : rd_ptr_q;
    level_d    = level_q + LW'(wr_en) - LW'(pop);

    // a drop in the same cycle as a clear restarts the count at one
    overflow_d = overflow_q;
    drop_cnt_d = drop_cnt_q;
    if (drop) begin
      overflow_d = 1'b1;
      if (ovf_clr)
        drop_cnt_d = DROP_W'(1);
      else if (!(&drop_cnt_q))
        drop_cnt_d = drop_cnt_q + DROP_W'(1);
    end else if (ovf_clr) begin
      overflow_d = 1'b0;
      drop_cnt_d = '0;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      last_val_q <= '0;
      last_vld_q <= 1'b0;
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      level_q    <= '0;
      overflow_q <= 1'b0;
      drop_cnt_q <= '0;
    end else begin
      last_val_q <= last_val_d;
      last_vld_q <= last_vld_d;
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      level_q    <= level_d;
      overflow_q <= overflow_d;
      drop_cnt_q <= drop_cnt_d;
    end
  end

`ifdef COUNT_CAPTURE_TSTAMP_EN
  logic [TSW-1:0] ts_q, ts_d;

  always_comb ts_d = ts_q + TSW'(1);

  always_ff @(posedge clk) begin
    if (reset)
      ts_q <= '0;
    else
      ts_q <= ts_d;
  end

  assign wr_data    = {ts_q, ent};
  assign out_tstamp = rd_data[EW-1 -: TSW];
`else
  assign wr_data    = ent;
  assign out_tstamp = '0;
`endif

  count_capture_mem #(
    .DEPTH (DEPTH),
    .W     (EW)
  ) u_mem (
    .clk     (clk),
    .reset   (reset),
    .wr_en   (wr_en),
    .wr_ptr  (wr_ptr_q),
    .wr_data (wr_data),
    .rd_ptr  (rd_ptr_d),
    .rd_data (rd_data)
  );

  assign out_valid = (level_q != '0);
  assign out_data  = rd_data[ENTRY_W-1:0];
  assign level     = level_q;
  assign overflow  = overflow_q;
  assign drop_cnt  = drop_cnt_q;

endmodule

// File: tb/tb_count_capture_fifo.sv
// Directed bench for count_capture_fifo (DEPTH=8, CW=4, TSW=8).
// Timestamp steps run only when COUNT_CAPTURE_TSTAMP_EN is defined.
module tb_count_capture_fifo;

  logic       clk = 1'b0;
  logic       reset;
  logic [3:0] count_in;
  logic       sample_en;
  logic       out_valid;
  logic       out_ready;
  logic [4:0] out_data;
  logic [7:0] out_tstamp;
  logic [3:0] level;
  logic       overflow;
  logic [7:0] drop_cnt;
  logic       ovf_clr;

  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  count_capture_fifo dut (
    .clk        (clk),
    .reset      (reset),
    .count_in   (count_in),
    .sample_en  (sample_en),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .out_data   (out_data),
    .out_tstamp (out_tstamp),
    .level      (level),
    .overflow   (overflow),
    .drop_cnt   (drop_cnt),
    .ovf_clr    (ovf_clr)
  );

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic chk(input string tag,
                     input logic [31:0] obs,
                     input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic fill8;
    sample_en = 1'b1;
    for (int i = 0; i < 8; i++) begin
      count_in = 4'(i);
      tick(1);
    end
    sample_en = 1'b0;
  endtask

  initial begin
    reset = 1'b1; count_in = '0; sample_en = 1'b0;
    out_ready = 1'b0; ovf_clr = 1'b0;
    tick(2);
    reset = 1'b0;
    chk("rst_valid", 32'(out_valid), 0);
    chk("rst_level", 32'(level), 0);
    chk("rst_ovf", 32'(overflow), 0);
    chk("rst_drop", 32'(drop_cnt), 0);
    chk("rst_data", 32'(out_data), 0);
    chk("rst_ts", 32'(out_tstamp), 0);

    // 3,3,4: second 3 is not a change
    sample_en = 1'b1; count_in = 4'd3;
    tick(1);
    chk("t1_valid", 32'(out_valid), 1);
    chk("t1_lvl1", 32'(level), 1);
    chk("t1_head", 32'(out_data), 5'h03);
    tick(1);
    chk("t1_dup", 32'(level), 1);
    count_in = 4'd4;
    tick(1);
    chk("t1_lvl2", 32'(level), 2);
    chk("t1_hold", 32'(out_data), 5'h03);
    sample_en = 1'b0; out_ready = 1'b1;
    tick(1);
    chk("t1_pop1", 32'(out_data), 5'h04);
    tick(1);
    chk("t1_empty", 32'(out_valid), 0);
    out_ready = 1'b0;

    // terminal count entry, then held value
    sample_en = 1'b1; count_in = 4'hE;
    tick(1);
    count_in = 4'hF;
    tick(11);
    chk("t2_lvl", 32'(level), 2);
    sample_en = 1'b0; out_ready = 1'b1;
    tick(1);
    chk("t2_tc", 32'(out_data), 5'h1F);
    tick(1);
    out_ready = 1'b0;

    // overrun: 11 pushes into 8 entries
    sample_en = 1'b1;
    for (int i = 0; i < 11; i++) begin
      count_in = 4'(i);
      tick(1);
    end
    sample_en = 1'b0;
    chk("t3_lvl", 32'(level), 8);
    chk("t3_ovf", 32'(overflow), 1);
    chk("t3_drop", 32'(drop_cnt), 3);
    out_ready = 1'b1;
    for (int i = 0; i < 8; i++) begin
      chk("t3_order", 32'(out_data), 32'(i));
      tick(1);
    end
    chk("t3_drained", 32'(level), 0);
    tick(2);
    chk("t3_no_uflow", 32'(level), 0);
    out_ready = 1'b0;
    ovf_clr = 1'b1;
    tick(1);
    ovf_clr = 1'b0;
    chk("clr_ovf", 32'(overflow), 0);
    chk("clr_drop", 32'(drop_cnt), 0);

    // full with simultaneous push and pop
    fill8();
    chk("t4_full", 32'(level), 8);
    out_ready = 1'b1; sample_en = 1'b1;
    for (int k = 0; k < 6; k++) begin
      count_in = 4'(8 + k);
      chk("t4_head", 32'(out_data), 32'(k));
      tick(1);
      chk("t4_lvl", 32'(level), 8);
    end
    sample_en = 1'b0;
    chk("t4_nodrop", 32'(drop_cnt), 0);
    for (int k = 6; k < 14; k++) begin
      chk("t4_order", 32'(out_data), 32'(k));
      tick(1);
    end
    chk("t4_empty", 32'(out_valid), 0);
    out_ready = 1'b0;

    // drop beats clear in the same cycle
    fill8();
    sample_en = 1'b1; count_in = 4'd9;
    tick(1);
    chk("dw_drop1", 32'(drop_cnt), 1);
    count_in = 4'd10; ovf_clr = 1'b1;
    tick(1);
    ovf_clr = 1'b0; sample_en = 1'b0;
    chk("dw_ovf", 32'(overflow), 1);
    chk("dw_cnt", 32'(drop_cnt), 1);

    // reset mid-operation
    out_ready = 1'b1;
    tick(3);
    out_ready = 1'b0;
    chk("t5_lvl5", 32'(level), 5);
    reset = 1'b1;
    tick(1);
    reset = 1'b0;
    chk("t5_lvl", 32'(level), 0);
    chk("t5_valid", 32'(out_valid), 0);
    chk("t5_ovf", 32'(overflow), 0);
    sample_en = 1'b1; count_in = 4'd10;
    tick(1);
    sample_en = 1'b0;
    chk("t5_repush", 32'(level), 1);
    chk("t5_data", 32'(out_data), 5'h0A);
    chk("t5_ts", 32'(out_tstamp), 0);

    // drop counter saturation: 270 pushes, 7 stored
    sample_en = 1'b1;
    for (int i = 0; i < 270; i++) begin
      count_in = 4'(i);
      tick(1);
    end
    sample_en = 1'b0;
    chk("sat_lvl", 32'(level), 8);
    chk("sat_drop", 32'(drop_cnt), 255);

`ifdef COUNT_CAPTURE_TSTAMP_EN
    reset = 1'b1;
    tick(1);
    reset = 1'b0;
    tick(2);
    sample_en = 1'b1; count_in = 4'd1;
    tick(1);
    sample_en = 1'b0;
    tick(257);
    sample_en = 1'b1; count_in = 4'd2;
    tick(1);
    sample_en = 1'b0;
    chk("ts_lvl", 32'(level), 2);
    chk("ts_first", 32'(out_tstamp), 2);
    out_ready = 1'b1;
    tick(1);
    out_ready = 1'b0;
    chk("ts_wrap", 32'(out_tstamp), 4);
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
